// File: rtl/markov_dfe_error_profiler.sv
// PAM4 1-tap DFE error-state profiler: histograms (tx, prev_state, outcome) transitions
// into a 112-entry counter table that is read back through an indexed port.
module markov_dfe_error_profiler #(
    parameter int COUNT_W = 32,
    parameter int TOTAL_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic [1:0]         tx_symbol,
    input  logic [1:0]         rx_symbol,
    output logic               busy,
    input  logic               rd_en,
    input  logic [6:0]         rd_idx,
    output logic               rd_valid,
    output logic [COUNT_W-1:0] rd_data,
    output logic [TOTAL_W-1:0] sym_count,
    output logic [TOTAL_W-1:0] err_count,
    output logic [2:0]         state_out
);

    localparam int DEPTH = 112;

    typedef enum logic {SWEEP, RUN} fsm_t;

    fsm_t               state_reg, state_next;
    logic [6:0]         sweep_addr_reg;
    logic [2:0]         prev_state_reg;
    logic [TOTAL_W-1:0] sym_count_reg, err_count_reg;
    logic               rd_valid_reg, rd_oob_reg;

    logic               s1_valid_reg;
    logic [6:0]         s1_idx_reg;
    logic               fwd_valid_reg;
    logic [6:0]         fwd_idx_reg;
    logic [COUNT_W-1:0] fwd_val_reg;

    // Two identical copies so the update pipeline and the host read never contend.
    logic [COUNT_W-1:0] upd_mem  [0:DEPTH-1];
    logic [COUNT_W-1:0] host_mem [0:DEPTH-1];
    logic [COUNT_W-1:0] upd_q_reg, host_q_reg;

    logic signed [2:0]  d;
    logic [2:0]         neg_d;
    logic [2:0]         new_state;
    logic [1:0]         outcome;
    logic [6:0]         upd_idx;
    logic [6:0]         host_addr;
    logic               accept, host_rd;
    logic [COUNT_W-1:0] s1_base, s1_next;
    logic               wr_en;
    logic [6:0]         wr_addr;
    logic [COUNT_W-1:0] wr_data;

    // FSM next-state and outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            SWEEP: begin
                busy = 1'b1;
                if (sweep_addr_reg == 7'(DEPTH - 1))
                    state_next = RUN;
            end
            RUN: begin
                if (clear)
                    state_next = SWEEP;
            end
            default: state_next = SWEEP;
        endcase
    end

    assign accept  = (state_reg == RUN) && !clear && en;
    assign host_rd = (state_reg == RUN) && !clear && rd_en;

    // Error state and outcome bin from D/2 = rx - tx
    always_comb begin
        d         = $signed({1'b0, rx_symbol}) - $signed({1'b0, tx_symbol});
        neg_d     = ~d + 3'd1;
        new_state = 3'd0;
        case (d)
            3'b001:  new_state = 3'd1;
            3'b111:  new_state = 3'd2;
            3'b010:  new_state = 3'd3;
            3'b110:  new_state = 3'd4;
            3'b011:  new_state = 3'd5;
            3'b101:  new_state = 3'd6;
            default: new_state = 3'd0;
        endcase
        outcome = 2'd0;
        case (tx_symbol)
            2'b00:   outcome = d[1:0];
            2'b11:   outcome = neg_d[1:0];
            default: begin
                case (d)
                    3'b000:  outcome = 2'd0;
                    3'b001:  outcome = 2'd1;
                    3'b111:  outcome = 2'd2;
                    default: outcome = 2'd3;
                endcase
            end
        endcase
        upd_idx = 7'(tx_symbol) * 7'd28 + {2'b00, prev_state_reg, 2'b00} + {5'b00000, outcome};
    end

    assign host_addr = (rd_idx < 7'(DEPTH)) ? rd_idx : 7'd0;

    // Stage 1: the previous cycle's write is not yet visible in upd_q_reg, so forward it.
    assign s1_base = (fwd_valid_reg && (fwd_idx_reg == s1_idx_reg)) ? fwd_val_reg : upd_q_reg;
    assign s1_next = (&s1_base) ? s1_base : s1_base + COUNT_W'(1);

    assign wr_en   = busy || s1_valid_reg;
    assign wr_addr = busy ? sweep_addr_reg : s1_idx_reg;
    assign wr_data = busy ? '0 : s1_next;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            upd_mem[wr_addr]  <= wr_data;
            host_mem[wr_addr] <= wr_data;
        end
        upd_q_reg  <= upd_mem[upd_idx];
        host_q_reg <= host_mem[host_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= SWEEP;
            sweep_addr_reg <= 7'd0;
            prev_state_reg <= 3'd0;
            sym_count_reg  <= '0;
            err_count_reg  <= '0;
            rd_valid_reg   <= 1'b0;
            rd_oob_reg     <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_idx_reg     <= 7'd0;
            fwd_valid_reg  <= 1'b0;
            fwd_idx_reg    <= 7'd0;
            fwd_val_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rd_valid_reg  <= host_rd;
            rd_oob_reg    <= (rd_idx >= 7'(DEPTH));
            s1_valid_reg  <= accept;
            s1_idx_reg    <= upd_idx;
            fwd_valid_reg <= s1_valid_reg;
            fwd_idx_reg   <= s1_idx_reg;
            fwd_val_reg   <= s1_next;

            if (state_reg == SWEEP)
                sweep_addr_reg <= (sweep_addr_reg == 7'(DEPTH - 1)) ? 7'd0 : sweep_addr_reg + 7'd1;

            if ((state_reg == RUN) && clear) begin
                sweep_addr_reg <= 7'd0;
                prev_state_reg <= 3'd0;
                sym_count_reg  <= '0;
                err_count_reg  <= '0;
            end else if (accept) begin
                prev_state_reg <= new_state;
                if (!(&sym_count_reg))
                    sym_count_reg <= sym_count_reg + TOTAL_W'(1);
                if ((rx_symbol != tx_symbol) && !(&err_count_reg))
                    err_count_reg <= err_count_reg + TOTAL_W'(1);
            end
        end
    end

    assign rd_valid  = rd_valid_reg;
    assign rd_data   = (rd_valid_reg && !rd_oob_reg) ? host_q_reg : '0;
    assign sym_count = sym_count_reg;
    assign err_count = err_count_reg;
    assign state_out = prev_state_reg;

endmodule

// File: tb/tb_markov_dfe_error_profiler.sv
// Directed bench for markov_dfe_error_profiler; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_markov_dfe_error_profiler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  tx_symbol = 2'b00;
    logic [1:0]  rx_symbol = 2'b00;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_idx = 7'd0;

    logic        busy, rd_valid;
    logic [31:0] rd_data;
    logic [47:0] sym_count, err_count;
    logic [2:0]  state_out;

    logic        busy4, rd_valid4;
    logic [3:0]  rd_data4;
    logic [47:0] sym_count4, err_count4;
    logic [2:0]  state_out4;

    int checks = 0;
    int fails  = 0;

    markov_dfe_error_profiler #(.COUNT_W(32), .TOTAL_W(48)) dut (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .tx_symbol(tx_symbol), .rx_symbol(rx_symbol), .busy(busy),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
        .sym_count(sym_count), .err_count(err_count), .state_out(state_out)
    );

    markov_dfe_error_profiler #(.COUNT_W(4), .TOTAL_W(48)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .en(en),
        .tx_symbol(tx_symbol), .rx_symbol(rx_symbol), .busy(busy4),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid4), .rd_data(rd_data4),
        .sym_count(sym_count4), .err_count(err_count4), .state_out(state_out4)
    );

    always #5 clk = ~clk;

    task automatic drive_pair(input logic [1:0] t, input logic [1:0] r);
        @(negedge clk);
        en = 1'b1;
        tx_symbol = t;
        rx_symbol = r;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
            clear = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    task automatic do_read(input int idx, output logic v, output logic [31:0] d, output logic [3:0] d4);
        @(negedge clk);
        en = 1'b0;
        rd_en = 1'b1;
        rd_idx = 7'(idx);
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_valid;
        d = rd_data;
        d4 = rd_data4;
        $display("read idx=%0d valid=%0b data=%0d data4=%0d", idx, v, d, d4);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_clear(output int n);
        @(negedge clk);
        en = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        count_busy(n);
    endtask

    task automatic test_reset;
        logic v; logic [31:0] d; logic [3:0] d4; int n;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %0b expected 1", busy); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        checks++; if (sym_count !== 48'd0) begin fails++; $display("FAIL reset_sym: got %0d expected 0", sym_count); end
        checks++; if (state_out !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        rst = 1'b0;
        count_busy(n);
        checks++; if (n != 112) begin fails++; $display("FAIL reset_sweep_len: got %0d expected 112", n); end
        for (int i = 0; i < 112; i++) begin
            do_read(i, v, d, d4);
            checks++; if (v !== 1'b1) begin fails++; $display("FAIL reset_rd_valid_%0d: got %0b expected 1", i, v); end
            checks++; if (d !== 32'd0) begin fails++; $display("FAIL reset_entry_%0d: got %0d expected 0", i, d); end
        end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse: got %0b expected 0", rd_valid); end
    endtask

    task automatic test_no_error;
        logic v; logic [31:0] d; logic [3:0] d4;
        int idxs[4] = '{0, 28, 56, 84};
        for (int i = 0; i < 1000; i++) drive_pair(2'(i % 4), 2'(i % 4));
        idle(2);
        for (int k = 0; k < 4; k++) begin
            do_read(idxs[k], v, d, d4);
            checks++; if (v !== 1'b1 || d !== 32'd250) begin fails++; $display("FAIL noerr_idx_%0d: got valid=%0b data=%0d expected valid=1 data=250", idxs[k], v, d); end
        end
        do_read(1, v, d, d4);
        checks++; if (d !== 32'd0) begin fails++; $display("FAIL noerr_idx_1: got %0d expected 0", d); end
        do_read(120, v, d, d4);
        checks++; if (v !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL oob_read: got valid=%0b data=%0d expected valid=1 data=0", v, d); end
        checks++; if (sym_count !== 48'd1000) begin fails++; $display("FAIL noerr_sym: got %0d expected 1000", sym_count); end
        checks++; if (err_count !== 48'd0) begin fails++; $display("FAIL noerr_err: got %0d expected 0", err_count); end
        checks++; if (state_out !== 3'd0) begin fails++; $display("FAIL noerr_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_error_seq;
        logic v; logic [31:0] d; logic [3:0] d4; int n;
        do_clear(n);
        checks++; if (n != 112) begin fails++; $display("FAIL seq_clear_len: got %0d expected 112", n); end
        drive_pair(2'b00, 2'b01);
        drive_pair(2'b10, 2'b10);
        drive_pair(2'b11, 2'b00);
        idle(2);
        do_read(1, v, d, d4);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL seq_idx_1: got %0d expected 1", d); end
        do_read(60, v, d, d4);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL seq_idx_60: got %0d expected 1", d); end
        do_read(87, v, d, d4);
        checks++; if (d !== 32'd1) begin fails++; $display("FAIL seq_idx_87: got %0d expected 1", d); end
        do_read(0, v, d, d4);
        checks++; if (d !== 32'd0) begin fails++; $display("FAIL seq_idx_0_cleared: got %0d expected 0", d); end
        checks++; if (state_out !== 3'd6) begin fails++; $display("FAIL seq_state: got %0d expected 6", state_out); end
        checks++; if (err_count !== 48'd2) begin fails++; $display("FAIL seq_err: got %0d expected 2", err_count); end
        checks++; if (sym_count !== 48'd3) begin fails++; $display("FAIL seq_sym: got %0d expected 3", sym_count); end
    endtask

    task automatic test_back_to_back;
        logic v; logic [31:0] d; logic [3:0] d4; int n;
        do_clear(n);
        for (int i = 0; i < 50; i++) drive_pair(2'b01, 2'b01);
        idle(2);
        do_read(28, v, d, d4);
        checks++; if (d !== 32'd50) begin fails++; $display("FAIL b2b_idx_28: got %0d expected 50", d); end
        checks++; if (sym_count !== 48'd50) begin fails++; $display("FAIL b2b_sym: got %0d expected 50", sym_count); end
    endtask

    task automatic test_saturation;
        logic v; logic [31:0] d; logic [3:0] d4; int n;
        do_clear(n);
        for (int i = 0; i < 20; i++) drive_pair(2'b00, 2'b00);
        idle(2);
        do_read(0, v, d, d4);
        checks++; if (d4 !== 4'd15) begin fails++; $display("FAIL sat_idx_0_w4: got %0d expected 15", d4); end
        checks++; if (d !== 32'd20) begin fails++; $display("FAIL sat_idx_0_w32: got %0d expected 20", d); end
        checks++; if (sym_count4 !== 48'd20) begin fails++; $display("FAIL sat_sym_w4: got %0d expected 20", sym_count4); end
    endtask

    task automatic test_clear_drop;
        logic v; logic [31:0] d; logic [3:0] d4; int n; logic rv_seen;
        do_clear(n);
        for (int i = 0; i < 10; i++) drive_pair(2'b00, 2'b00);
        @(negedge clk);
        checks++; if (sym_count !== 48'd10) begin fails++; $display("FAIL drop_pre_sym: got %0d expected 10", sym_count); end
        en = 1'b1; tx_symbol = 2'b00; rx_symbol = 2'b01; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tx_symbol = 2'b11; rx_symbol = 2'b00;
        rd_en = 1'b1; rd_idx = 7'd0;
        n = 0; rv_seen = 1'b0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            if (rd_valid !== 1'b0) rv_seen = 1'b1;
            @(negedge clk);
        end
        en = 1'b0; rd_en = 1'b0;
        checks++; if (n != 112) begin fails++; $display("FAIL drop_sweep_len: got %0d expected 112", n); end
        checks++; if (rv_seen !== 1'b0) begin fails++; $display("FAIL drop_rd_while_busy: got %0b expected 0", rv_seen); end
        checks++; if (sym_count !== 48'd0) begin fails++; $display("FAIL drop_sym: got %0d expected 0", sym_count); end
        checks++; if (err_count !== 48'd0) begin fails++; $display("FAIL drop_err: got %0d expected 0", err_count); end
        checks++; if (state_out !== 3'd0) begin fails++; $display("FAIL drop_state: got %0d expected 0", state_out); end
        for (int i = 0; i < 112; i++) begin
            do_read(i, v, d, d4);
            checks++; if (v !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL drop_entry_%0d: got valid=%0b data=%0d expected valid=1 data=0", i, v, d); end
        end
        // Reset in the middle of a sweep restarts it from entry 0.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy: got %0b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        checks++; if (n != 112) begin fails++; $display("FAIL midsweep_restart_len: got %0d expected 112", n); end
    endtask

    initial begin
        test_reset;
        test_no_error;
        test_error_seq;
        test_back_to_back;
        test_saturation;
        test_clear_drop;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
